// File: rtl/seq_alu_pkg.sv
// ============================================================================
//  Package : riscv_structures
//  Purpose : Shared types for the sequential execute-stage ALU: operation
//            encoding, branch-condition funct3 values and FSM state encoding.
//  Revision: 1.0  initial release
// ============================================================================
`default_nettype none

package riscv_structures;

    // Operation select. RV32I ops first, M-extension ops grouped at the end.
    typedef enum logic [4:0] {
        ADD    = 5'd0,
        SUB    = 5'd1,
        SLL    = 5'd2,
        SLT    = 5'd3,
        SLTU   = 5'd4,
        XOR    = 5'd5,
        SRL    = 5'd6,
        SRA    = 5'd7,
        OR     = 5'd8,
        AND    = 5'd9,
        MUL    = 5'd10,
        MULH   = 5'd11,
        MULHSU = 5'd12,
        MULHU  = 5'd13,
        DIV    = 5'd14,
        DIVU   = 5'd15,
        REM    = 5'd16,
        REMU   = 5'd17
    } alu_op_e;

    // Branch condition encodings (funct3 of the B-type instructions).
    localparam logic [2:0] BR_EQ  = 3'd0;
    localparam logic [2:0] BR_NE  = 3'd1;
    localparam logic [2:0] BR_LT  = 3'd4;
    localparam logic [2:0] BR_GE  = 3'd5;
    localparam logic [2:0] BR_LTU = 3'd6;
    localparam logic [2:0] BR_GEU = 3'd7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } alu_state_e;

endpackage

`default_nettype wire

// File: rtl/seq_alu_mdu_iter.sv
// ============================================================================
//  Module  : seq_alu_mdu_iter
//  Purpose : Iterative multiply / divide datapath. Multiplies by shift-add and
//            divides by restoring division, both on operand magnitudes,
//            retiring STEP_BITS bits per cycle. Signs are reapplied to the
//            combinational result of the final step.
//  Ports   : clk, rst     clock, asynchronous active-high reset
//            kill_i       abandon any operation in progress
//            start_i      load operands and begin (op_i, a_i, b_i sampled)
//            op_i         M-extension operation
//            a_i, b_i     operands
//            done_o       high in the cycle the final step is computed
//            result_o     final result, valid while done_o is high
//  Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module seq_alu_mdu_iter
    import riscv_structures::*;
#(
    parameter int XLEN      = 32,
    parameter int STEP_BITS = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            kill_i,
    input  logic            start_i,
    input  alu_op_e         op_i,
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    output logic            done_o,
    output logic [XLEN-1:0] result_o
);

    localparam int NSTEP = XLEN / STEP_BITS;
    localparam int CW    = $clog2(NSTEP + 1);
    // Step index of the final iteration; the counter would read NSTEP after it.
    localparam logic [CW-1:0] LAST = CW'(NSTEP - 1);

    logic            busy_q;
    logic [CW-1:0]   cnt_q;
    logic [XLEN-1:0] hi_q;      // product high half / partial remainder
    logic [XLEN-1:0] lo_q;      // multiplier, shifting out / quotient, shifting in
    logic [XLEN-1:0] b_q;       // multiplicand / divisor magnitude
    logic            is_div_q;
    logic            sel_alt_q; // high product half (MULH*) or remainder (REM*)
    logic            neg_main_q;
    logic            neg_rem_q;

    logic            a_sgn;
    logic            b_sgn;
    logic [XLEN-1:0] hi_nx;
    logic [XLEN-1:0] lo_nx;
    logic [XLEN:0]   sum;
    logic [XLEN:0]   shd;
    logic [2*XLEN-1:0] prod;
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0] quo_fix;
    logic [XLEN-1:0] rem_fix;

    // Operand signedness per op; only a negative signed operand is corrected.
    assign a_sgn = ((op_i == MULH) || (op_i == MULHSU) || (op_i == DIV) || (op_i == REM))
                   && a_i[XLEN-1];
    assign b_sgn = ((op_i == MULH) || (op_i == DIV) || (op_i == REM)) && b_i[XLEN-1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q     <= 1'b0;
            cnt_q      <= '0;
            hi_q       <= '0;
            lo_q       <= '0;
            b_q        <= '0;
            is_div_q   <= 1'b0;
            sel_alt_q  <= 1'b0;
            neg_main_q <= 1'b0;
            neg_rem_q  <= 1'b0;
        end else if (kill_i) begin
            busy_q <= 1'b0;
            cnt_q  <= '0;
        end else if (start_i) begin
            busy_q     <= 1'b1;
            cnt_q      <= '0;
            hi_q       <= '0;
            lo_q       <= a_sgn ? -a_i : a_i;
            b_q        <= b_sgn ? -b_i : b_i;
            is_div_q   <= (op_i == DIV) || (op_i == DIVU) || (op_i == REM) || (op_i == REMU);
            sel_alt_q  <= (op_i == MULH) || (op_i == MULHSU) || (op_i == MULHU)
                          || (op_i == REM) || (op_i == REMU);
            neg_main_q <= a_sgn ^ b_sgn;
            neg_rem_q  <= a_sgn;
        end else if (busy_q) begin
            hi_q <= hi_nx;
            lo_q <= lo_nx;
            if (cnt_q == LAST) begin
                busy_q <= 1'b0;
                cnt_q  <= '0;
            end else begin
                cnt_q <= cnt_q + CW'(1);
            end
        end
    end

    // STEP_BITS single-bit iterations unrolled per cycle.
    always_comb begin
        hi_nx = hi_q;
        lo_nx = lo_q;
        sum   = '0;
        shd   = '0;
        for (int k = 0; k < STEP_BITS; k++) begin
            if (is_div_q) begin
                shd   = {hi_nx, lo_nx[XLEN-1]};
                lo_nx = {lo_nx[XLEN-2:0], 1'b0};
                if (shd >= {1'b0, b_q}) begin
                    // Difference is below the divisor, so the low XLEN bits are exact.
                    hi_nx    = shd[XLEN-1:0] - b_q;
                    lo_nx[0] = 1'b1;
                end else begin
                    hi_nx = shd[XLEN-1:0];
                end
            end else begin
                sum   = {1'b0, hi_nx} + (lo_nx[0] ? {1'b0, b_q} : {(XLEN+1){1'b0}});
                lo_nx = {sum[0], lo_nx[XLEN-1:1]};
                hi_nx = sum[XLEN:1];
            end
        end
    end

    assign prod     = {hi_nx, lo_nx};
    assign prod_fix = neg_main_q ? -prod : prod;
    assign quo_fix  = neg_main_q ? -lo_nx : lo_nx;
    assign rem_fix  = neg_rem_q ? -hi_nx : hi_nx;

    assign done_o   = busy_q && (cnt_q == LAST);
    assign result_o = is_div_q ? (sel_alt_q ? rem_fix : quo_fix)
                               : (sel_alt_q ? prod_fix[2*XLEN-1:XLEN] : prod_fix[XLEN-1:0]);

endmodule

`default_nettype wire

// File: rtl/seq_alu.sv
// ============================================================================
//  Module  : seq_alu
//  Purpose : Handshaked execute-stage ALU. RV32I integer ops and the six
//            branch conditions complete in one cycle; M-extension ops run on
//            an iterative unit when the build enables it.
//  Config  : SEQ_ALU_MDU_EN  defined   -> iterative MUL/DIV/REM unit present
//                            undefined -> M ops return 0 with illegal=1
//  Ports   : clk, rst               clock, asynchronous active-high reset
//            flush                  synchronous kill of any in-flight op
//            in_valid / in_ready    input handshake (ready only in IDLE)
//            in1, in2, alu_op       operands and operation
//            funct3                 branch condition select
//            out_valid / out_ready  output handshake (valid in DONE)
//            result, cond, illegal  registered outputs
//  Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module seq_alu
    import riscv_structures::*;
#(
    parameter int XLEN      = 32,
    parameter int STEP_BITS = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] in1,
    input  logic [XLEN-1:0] in2,
    input  alu_op_e         alu_op,
    input  logic [2:0]      funct3,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            cond,
    output logic            illegal
);

    localparam int SHW = $clog2(XLEN);

    alu_state_e      state_q, state_d;
    logic [XLEN-1:0] result_q, result_d;
    logic            cond_q, cond_d;
    logic            illegal_q, illegal_d;

    logic            accept;
    logic [SHW-1:0]  shamt;
    logic [XLEN-1:0] sc_res;
    logic            sc_ill;
    logic            go_iter;
    logic            cond_w;
    logic            mdu_done;
    logic [XLEN-1:0] mdu_result;

    assign in_ready = (state_q == IDLE) && !rst;
    assign accept   = in_valid && in_ready;
    assign shamt    = in2[SHW-1:0];

`ifdef SEQ_ALU_MDU_EN
    localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};
    logic div0;
    logic sovf;
    // Special divide cases resolve at accept and never enter the iterative unit.
    assign div0 = (in2 == '0);
    assign sovf = (in1 == MOST_NEG) && (in2 == '1);
`endif

    // Single-cycle datapath; also decides whether the op needs the iterative unit.
    always_comb begin
        sc_res  = '0;
        sc_ill  = 1'b0;
        go_iter = 1'b0;
        case (alu_op)
            ADD:  sc_res = in1 + in2;
            SUB:  sc_res = in1 - in2;
            AND:  sc_res = in1 & in2;
            OR:   sc_res = in1 | in2;
            XOR:  sc_res = in1 ^ in2;
            SLL:  sc_res = in1 << shamt;
            SRL:  sc_res = in1 >> shamt;
            SRA:  sc_res = $unsigned($signed(in1) >>> shamt);
            SLT:  sc_res = {{(XLEN-1){1'b0}}, $signed(in1) < $signed(in2)};
            SLTU: sc_res = {{(XLEN-1){1'b0}}, in1 < in2};
`ifdef SEQ_ALU_MDU_EN
            MUL, MULH, MULHSU, MULHU: go_iter = 1'b1;
            DIV: begin
                if (div0)      sc_res = '1;
                else if (sovf) sc_res = in1;
                else           go_iter = 1'b1;
            end
            DIVU: begin
                if (div0) sc_res = '1;
                else      go_iter = 1'b1;
            end
            REM: begin
                if (div0)      sc_res = in1;
                else if (sovf) sc_res = '0;
                else           go_iter = 1'b1;
            end
            REMU: begin
                if (div0) sc_res = in1;
                else      go_iter = 1'b1;
            end
`else
            MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU: sc_ill = 1'b1;
`endif
            default: sc_res = '0;
        endcase
    end

    always_comb begin
        cond_w = 1'b0;
        case (funct3)
            BR_EQ:   cond_w = (in1 == in2);
            BR_NE:   cond_w = (in1 != in2);
            BR_LT:   cond_w = ($signed(in1) < $signed(in2));
            BR_GE:   cond_w = ($signed(in1) >= $signed(in2));
            BR_LTU:  cond_w = (in1 < in2);
            BR_GEU:  cond_w = (in1 >= in2);
            default: cond_w = 1'b0;
        endcase
    end

`ifdef SEQ_ALU_MDU_EN
    seq_alu_mdu_iter #(
        .XLEN      (XLEN),
        .STEP_BITS (STEP_BITS)
    ) u_mdu (
        .clk      (clk),
        .rst      (rst),
        .kill_i   (flush),
        .start_i  (accept && go_iter && !flush),
        .op_i     (alu_op),
        .a_i      (in1),
        .b_i      (in2),
        .done_o   (mdu_done),
        .result_o (mdu_result)
    );
`else
    assign mdu_done   = 1'b0;
    assign mdu_result = '0;
`endif

    // FSM and output-register next state. flush outranks every transition but
    // leaves result/cond untouched.
    always_comb begin
        state_d   = state_q;
        result_d  = result_q;
        cond_d    = cond_q;
        illegal_d = illegal_q;
        if (flush) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        cond_d    = cond_w;
                        illegal_d = sc_ill;
                        if (go_iter) begin
                            state_d = BUSY;
                        end else begin
                            state_d  = DONE;
                            result_d = sc_res;
                        end
                    end
                end
                BUSY: begin
                    if (mdu_done) begin
                        state_d  = DONE;
                        result_d = mdu_result;
                    end
                end
                DONE: begin
                    if (out_ready) state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            result_q  <= '0;
            cond_q    <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            result_q  <= result_d;
            cond_q    <= cond_d;
            illegal_q <= illegal_d;
        end
    end

    assign out_valid = (state_q == DONE);
    assign result    = result_q;
    assign cond      = cond_q;
    assign illegal   = illegal_q;

endmodule

`default_nettype wire

// File: tb/tb_seq_alu.sv
// ============================================================================
//  Module  : tb_seq_alu
//  Purpose : Self-checking bench for seq_alu (XLEN 32, STEP_BITS 1): vector
//            table of single ops plus hand sequences for hold, flush and reset.
//            M-op expectations follow SEQ_ALU_MDU_EN.
//  Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module tb_seq_alu;
    import riscv_structures::*;

    localparam int ITER_LAT = 32 / 1 + 1;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [31:0] in1 = '0;
    logic [31:0] in2 = '0;
    alu_op_e     alu_op = ADD;
    logic [2:0]  funct3 = '0;
    logic        in_ready;
    logic        out_valid;
    logic [31:0] result;
    logic        cond;
    logic        illegal;

    int total = 0;
    int bad   = 0;

    seq_alu #(.XLEN(32), .STEP_BITS(1)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in1       (in1),
        .in2       (in2),
        .alu_op    (alu_op),
        .funct3    (funct3),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .cond      (cond),
        .illegal   (illegal)
    );

    always #5 clk = ~clk;

    typedef struct {
        alu_op_e     op;
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  f3;
        logic [31:0] res;
        logic        cnd;
        logic        ill;
        int          lat;
        string       nm;
    } vec_t;

    vec_t vecs[$];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic add_v(input alu_op_e op, input logic [31:0] a, input logic [31:0] b,
                         input logic [2:0] f3, input logic [31:0] res, input logic c,
                         input logic ill, input int lat, input string nm);
        vec_t v;
        v.op = op; v.a = a; v.b = b; v.f3 = f3; v.res = res;
        v.cnd = c; v.ill = ill; v.lat = lat; v.nm = nm;
        vecs.push_back(v);
    endtask

    // M ops: real result and latency when the unit is built, otherwise illegal.
    task automatic add_m(input alu_op_e op, input logic [31:0] a, input logic [31:0] b,
                         input logic [2:0] f3, input logic [31:0] res, input logic c,
                         input int lat, input string nm);
`ifdef SEQ_ALU_MDU_EN
        add_v(op, a, b, f3, res, c, 1'b0, lat, nm);
`else
        add_v(op, a, b, f3, 32'h0, c, 1'b1, 1, nm);
`endif
    endtask

    task automatic run_op(input vec_t v);
        int lat;
        chk({v.nm, " in_ready"}, {31'b0, in_ready}, 32'd1);
        in_valid = 1'b1; alu_op = v.op; in1 = v.a; in2 = v.b; funct3 = v.f3;
        tick();
        in_valid = 1'b0; in1 = $urandom; in2 = $urandom; funct3 = 3'($urandom);
        lat = 1;
        while (!out_valid && lat < 200) begin
            tick();
            lat++;
        end
        chk({v.nm, " out_valid"}, {31'b0, out_valid}, 32'd1);
        chk({v.nm, " latency"}, lat, v.lat);
        chk({v.nm, " result"}, result, v.res);
        chk({v.nm, " cond"}, {31'b0, cond}, {31'b0, v.cnd});
        chk({v.nm, " illegal"}, {31'b0, illegal}, {31'b0, v.ill});
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk({v.nm, " drained"}, {31'b0, out_valid}, 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen;

        // Reset state
        tick();
        chk("rst in_ready", {31'b0, in_ready}, 32'd0);
        chk("rst out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst result", result, 32'h0);
        chk("rst cond", {31'b0, cond}, 32'd0);
        chk("rst illegal", {31'b0, illegal}, 32'd0);
        rst = 1'b0;
        tick();

        add_v(ADD,  32'hFFFFFFFF, 32'h1,        3'd0, 32'h0,        1'b0, 1'b0, 1, "add_wrap");
        add_v(SUB,  32'h5,        32'h7,        3'd1, 32'hFFFFFFFE, 1'b1, 1'b0, 1, "sub");
        add_v(AND,  32'hF0F0F0F0, 32'h0FF00FF0, 3'd4, 32'h00F000F0, 1'b1, 1'b0, 1, "and");
        add_v(OR,   32'hF0F0F0F0, 32'h0FF00FF0, 3'd6, 32'hFFF0FFF0, 1'b0, 1'b0, 1, "or");
        add_v(XOR,  32'hF0F0F0F0, 32'h0FF00FF0, 3'd7, 32'hFF00FF00, 1'b1, 1'b0, 1, "xor");
        add_v(SLL,  32'h1,        32'h1F,       3'd2, 32'h80000000, 1'b0, 1'b0, 1, "sll");
        add_v(SRL,  32'h80000000, 32'h21,       3'd3, 32'h40000000, 1'b0, 1'b0, 1, "srl");
        add_v(SRA,  32'h80000000, 32'h21,       3'd5, 32'hC0000000, 1'b0, 1'b0, 1, "sra");
        add_v(SLT,  32'hFFFFFFFF, 32'h0,        3'd5, 32'h1,        1'b0, 1'b0, 1, "slt");
        add_v(SLTU, 32'hFFFFFFFF, 32'h0,        3'd7, 32'h0,        1'b1, 1'b0, 1, "sltu");
        add_v(ADD,  32'h7,        32'h7,        3'd0, 32'hE,        1'b1, 1'b0, 1, "add_eq");
        add_m(MUL,    32'hFFFFFFFF, 32'h2, 3'd1, 32'hFFFFFFFE, 1'b1, ITER_LAT, "mul");
        add_m(MULHU,  32'hFFFFFFFF, 32'h2, 3'd0, 32'h1,        1'b0, ITER_LAT, "mulhu");
        add_m(MULH,   32'hFFFFFFFF, 32'h2, 3'd6, 32'hFFFFFFFF, 1'b0, ITER_LAT, "mulh");
        add_m(MULHSU, 32'hFFFFFFFF, 32'h2, 3'd4, 32'hFFFFFFFF, 1'b1, ITER_LAT, "mulhsu");
        add_m(MUL,    32'h12345678, 32'h10, 3'd7, 32'h23456780, 1'b1, ITER_LAT, "mul_big");
        add_m(DIV,    32'hFFFFFFF9, 32'h2, 3'd5, 32'hFFFFFFFD, 1'b0, ITER_LAT, "div_neg");
        add_m(REM,    32'hFFFFFFF9, 32'h2, 3'd1, 32'hFFFFFFFF, 1'b1, ITER_LAT, "rem_neg");
        add_m(DIVU,   32'h64,       32'h7, 3'd7, 32'hE,        1'b1, ITER_LAT, "divu");
        add_m(REMU,   32'h64,       32'h7, 3'd0, 32'h2,        1'b0, ITER_LAT, "remu");
        add_m(REM,    32'h7, 32'hFFFFFFFE, 3'd4, 32'h1,        1'b0, ITER_LAT, "rem_negdiv");
        add_m(DIV,    32'h1234,     32'h0, 3'd1, 32'hFFFFFFFF, 1'b1, 1, "div_by0");
        add_m(REMU,   32'h5,        32'h0, 3'd7, 32'h5,        1'b1, 1, "remu_by0");
        add_m(DIV,    32'h80000000, 32'hFFFFFFFF, 3'd4, 32'h80000000, 1'b1, 1, "div_ovf");
        add_m(REM,    32'h80000000, 32'hFFFFFFFF, 3'd0, 32'h0,        1'b0, 1, "rem_ovf");

        foreach (vecs[i]) run_op(vecs[i]);

        // Hold: out_ready low for 3 cycles while a second op is offered.
        in_valid = 1'b1; alu_op = ADD; in1 = 32'hFFFFFFFF; in2 = 32'h1; funct3 = 3'd0;
        tick();
        alu_op = ADD; in1 = 32'h1; in2 = 32'h1; funct3 = 3'd0;
        chk("hold first valid", {31'b0, out_valid}, 32'd1);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("hold valid", {31'b0, out_valid}, 32'd1);
            chk("hold result", result, 32'h0);
            chk("hold in_ready", {31'b0, in_ready}, 32'd0);
        end
        in_valid = 1'b0; out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("hold released", {31'b0, out_valid}, 32'd0);

        // Flush in the middle of a DIVU: nothing must ever come out.
        in_valid = 1'b1; alu_op = DIVU; in1 = 32'h64; in2 = 32'h7; funct3 = 3'd1;
        tick();
        in_valid = 1'b0;
`ifdef SEQ_ALU_MDU_EN
        repeat (9) tick();
`endif
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flush out_valid", {31'b0, out_valid}, 32'd0);
        chk("flush in_ready", {31'b0, in_ready}, 32'd1);
        seen = 1'b0;
        for (int k = 0; k < 40; k++) begin
            tick();
            if (out_valid) seen = 1'b1;
        end
        chk("flush never valid", {31'b0, seen}, 32'd0);
        begin
            vec_t v;
            v.op = ADD; v.a = 32'h2; v.b = 32'h3; v.f3 = 3'd1; v.res = 32'h5;
            v.cnd = 1'b1; v.ill = 1'b0; v.lat = 1; v.nm = "post_flush_add";
            run_op(v);
        end

        // Asynchronous reset in the middle of a DIVU.
        in_valid = 1'b1; alu_op = DIVU; in1 = 32'h64; in2 = 32'h7; funct3 = 3'd1;
        tick();
        in_valid = 1'b0;
        repeat (4) tick();
        #2 rst = 1'b1;
        #1;
        chk("arst out_valid", {31'b0, out_valid}, 32'd0);
        chk("arst result", result, 32'h0);
        chk("arst cond", {31'b0, cond}, 32'd0);
        chk("arst illegal", {31'b0, illegal}, 32'd0);
        chk("arst in_ready", {31'b0, in_ready}, 32'd0);
        rst = 1'b0;
        tick();
        chk("arst released ready", {31'b0, in_ready}, 32'd1);
        repeat (40) tick();
        chk("arst stays idle", {31'b0, out_valid}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
